hier_fanin_node: RTL and testbench
==================================

HIER_FANIN_NODE -- requirements
Module: hier_fanin_node

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 10: number of child input channels (legal 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8: payload width per channel.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2: per-channel buffer depth (legal 2..8).
REQ-004 The block SHALL have parameter ARB_MODE, default ARB_RR: arbitration mode (ARB_RR round-robin, ARB_FIXED lowest-index-wins).
REQ-005 The block SHALL have derived localparam ID_W = $clog2(NUM_CH).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, NUM_CH bits: per-channel data valid.
REQ-009 The block SHALL have port in_ready, output, NUM_CH bits: per-channel accept.
REQ-010 The block SHALL have port in_data, input, NUM_CH*DATA_W bits: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 The block SHALL have port out_valid, output, 1 bit: upstream data valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: upstream accept.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: granted payload.
REQ-014 The block SHALL have port out_id, output, ID_W bits: index of the source channel.
REQ-015 The block SHALL have port xfer_cnt, output, 16 bits: count of completed upstream transfers.

Function
REQ-016 Input channel i SHALL transfer on a cycle with in_valid[i] && in_ready[i], and in_ready[i] SHALL equal "FIFO i not full" (no pass-through into a full FIFO).
REQ-017 A simultaneous push and pop on a non-full FIFO SHALL both take effect, leaving the occupancy unchanged.
REQ-018 The output register SHALL load when (!out_valid || out_ready) and at least one FIFO is non-empty; each load pops exactly one entry from the granted FIFO.
REQ-019 Latency SHALL be 2 cycles: input accepted at edge t gives out_valid at edge t+2 when the output is free.
REQ-020 Back-to-back loads SHALL sustain 1 transfer/cycle with out_ready held high.
REQ-021 In ARB_RR mode the block SHALL grant the first non-empty channel searching from (last_grant+1) mod NUM_CH, wrapping NUM_CH-1 -> 0.
REQ-022 The RR pointer SHALL update only on a load.
REQ-023 In ARB_FIXED mode the block SHALL grant the lowest-index non-empty channel.
REQ-024 While out_valid && !out_ready, out_valid, out_data and out_id SHALL hold stable and no FIFO SHALL pop.
REQ-025 xfer_cnt SHALL increment on each out_valid && out_ready and wrap from 16'hFFFF to 0.
REQ-026 Per-channel ordering SHALL be preserved FIFO order; no entry is dropped or duplicated.

Reset
REQ-027 While rst=1 the block SHALL hold in_ready=0, out_valid=0, out_data=0, out_id=0 and xfer_cnt=0.
REQ-028 While rst=1 all FIFOs SHALL be empty and the RR pointer SHALL be NUM_CH-1, so the first grant searches from channel 0.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered and presented data at the next edge.
REQ-030 in_ready SHALL rise on the first cycle after rst deasserts.

Structure
REQ-031 Package hier_node_pkg SHALL hold the arb_mode_e enum (ARB_RR, ARB_FIXED) and the default constants for NUM_CH, DATA_W and FIFO_DEPTH.
REQ-032 The per-channel buffer SHALL be the sub-module hier_node_fifo (params DATA_W, DEPTH; push/pop/full/empty), instantiated NUM_CH times in a generate loop.
REQ-033 The arbiter and output register SHALL live in hier_fanin_node.

Verification
REQ-034 Single beat: in_valid[3]=1 with data 8'hA5 at cycle 0 -> out_valid=1, out_data=A5, out_id=3 at cycle 2; xfer_cnt becomes 1 after the handshake.
REQ-035 RR fairness: all 10 channels continuously valid and out_ready=1 -> out_id sequence 0,1,...,9,0 with no bubbles.
REQ-036 Fixed mode: channels 2 and 7 continuously valid -> only id 2 is granted.
REQ-037 Backpressure: out_ready=0 for 5 cycles with channel 0 streaming -> in_ready[0]=0 after 3 accepts (FIFO_DEPTH 2 plus 1 in the output register), out_data stable; on release the data drains in order.
REQ-038 Reset mid-stream: assert rst for 1 cycle with FIFOs partially full -> out_valid=0 and xfer_cnt=0 next cycle; the prior data is never output.
REQ-039 Counter wrap: preload the count by driving 65536 transfers -> xfer_cnt reads 0.

Source files
------------

// File: rtl/hier_node_pkg.sv
// Shared types and default sizing for the hierarchical fan-in node.
package hier_node_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int DEF_NUM_CH     = 10;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 2;

endpackage

// File: rtl/hier_node_fifo.sv
// Per-channel circular buffer; push is ignored when full, pop when empty.
module hier_node_fifo
  import hier_node_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hier_fanin_node.sv
// Merges NUM_CH buffered child channels into one registered upstream stream
// using round-robin or fixed-priority arbitration.
module hier_fanin_node
  import hier_node_pkg::*;
#(
  parameter int        NUM_CH     = DEF_NUM_CH,
  parameter int        DATA_W     = DEF_DATA_W,
  parameter int        FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  localparam int       ID_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic [15:0]              xfer_cnt
);

  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_pop;
  logic [DATA_W-1:0] fifo_q [NUM_CH];
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic              load;
  int                idx;

  assign in_ready = rst ? '0 : ~fifo_full;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    hier_node_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[g] && in_ready[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (fifo_pop[g]),
      .pop_data  (fifo_q[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Round-robin scans from the channel after the last grant, wrapping once.
  always_comb begin
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_found && !fifo_empty[i]) begin
          grant_id    = ID_W'(i);
          grant_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        if (!grant_found && !fifo_empty[ID_W'(idx)]) begin
          grant_id    = ID_W'(idx);
          grant_found = 1'b1;
        end
      end
    end
  end

  assign load = (!out_valid || out_ready) && grant_found;

  always_comb begin
    fifo_pop = '0;
    if (load) begin
      fifo_pop[grant_id] = 1'b1;
    end
  end

  // Output register holds while stalled; the RR pointer moves only on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      xfer_cnt  <= '0;
      rr_ptr    <= ID_W'(NUM_CH - 1);
    end else begin
      if (out_valid && out_ready) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= fifo_q[grant_id];
        out_id    <= grant_id;
        rr_ptr    <= grant_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hier_fanin_node.sv
// Randomised and directed bench for hier_fanin_node; a round-robin and a
// fixed-priority instance share stimulus and are checked against a queue model.
module tb_hier_fanin_node;
  import hier_node_pkg::*;

  localparam int NUM_CH = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int ID_W   = $clog2(NUM_CH);

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_ready;

  logic [NUM_CH-1:0] dut_in_ready  [2];
  logic              dut_out_valid [2];
  logic [DATA_W-1:0] dut_out_data  [2];
  logic [ID_W-1:0]   dut_out_id    [2];
  logic [15:0]       dut_xfer_cnt  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: m = 0 round-robin instance, m = 1 fixed-priority instance.
  logic [DATA_W-1:0] m_mem  [2][NUM_CH][DEPTH];
  int                m_cnt  [2][NUM_CH];
  bit                m_ov   [2];
  logic [DATA_W-1:0] m_od   [2];
  int                m_oid  [2];
  int                m_last [2];
  int                m_xfer [2];

  hier_fanin_node #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[0]),
    .in_data(in_data), .out_valid(dut_out_valid[0]), .out_ready(out_ready),
    .out_data(dut_out_data[0]), .out_id(dut_out_id[0]), .xfer_cnt(dut_xfer_cnt[0])
  );

  hier_fanin_node #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)
  ) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[1]),
    .in_data(in_data), .out_valid(dut_out_valid[1]), .out_ready(out_ready),
    .out_data(dut_out_data[1]), .out_id(dut_out_id[1]), .xfer_cnt(dut_xfer_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int m, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst=%0d actual=%h required=%h t=%0t", name, m, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NUM_CH-1:0] v,
                               input logic [NUM_CH*DATA_W-1:0] d, input logic rdy);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] rand_data();
    logic [NUM_CH*DATA_W-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  // Reference model: per-channel queues plus a one-entry output slot.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int c = 0; c < NUM_CH; c++) m_cnt[m][c] = 0;
        m_ov[m] = 1'b0; m_od[m] = '0; m_oid[m] = 0; m_xfer[m] = 0;
        m_last[m] = NUM_CH - 1;
      end else begin
        bit acc [NUM_CH];
        int g;
        for (int c = 0; c < NUM_CH; c++) acc[c] = in_valid[c] && (m_cnt[m][c] < DEPTH);
        if (m_ov[m] && out_ready) m_xfer[m] = (m_xfer[m] + 1) % 65536;
        g = -1;
        if (!m_ov[m] || out_ready) begin
          for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m == 0) ? (m_last[m] + k) % NUM_CH : k - 1;
            if (g < 0 && m_cnt[m][c] > 0) g = c;
          end
        end
        if (g >= 0) begin
          m_od[m] = m_mem[m][g][0];
          for (int j = 0; j < DEPTH - 1; j++) m_mem[m][g][j] = m_mem[m][g][j+1];
          m_cnt[m][g]--;
          m_ov[m]   = 1'b1;
          m_oid[m]  = g;
          m_last[m] = g;
        end else if (out_ready) begin
          m_ov[m] = 1'b0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (acc[c]) begin
            m_mem[m][c][m_cnt[m][c]] = in_data[c*DATA_W +: DATA_W];
            m_cnt[m][c]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [NUM_CH-1:0] exp_rdy;
      for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = !rst && (m_cnt[m][c] < DEPTH);
      checkOutput("in_ready", m, 32'(dut_in_ready[m]), 32'(exp_rdy));
      checkOutput("out_valid", m, 32'(dut_out_valid[m]), 32'(m_ov[m]));
      if (m_ov[m]) begin
        checkOutput("out_data", m, 32'(dut_out_data[m]), 32'(m_od[m]));
        checkOutput("out_id", m, 32'(dut_out_id[m]), 32'(m_oid[m]));
      end
      checkOutput("xfer_cnt", m, 32'(dut_xfer_cnt[m]), 32'(m_xfer[m]));
    end
  end

  initial begin
    logic [NUM_CH*DATA_W-1:0] d;
    int ids [$];
    int seen;
    int hs;

    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    applyStimulus(1, '0, '0, 0);
    applyStimulus(1, '0, '0, 0);
    checkOutput("rst_out_valid", 0, 32'(dut_out_valid[0]), 32'd0);
    checkOutput("rst_xfer_cnt", 0, 32'(dut_xfer_cnt[0]), 32'd0);
    checkOutput("rst_in_ready", 1, 32'(dut_in_ready[1]), 32'd0);

    // Single beat on channel 3.
    d = '0;
    d[3*DATA_W +: DATA_W] = 8'hA5;
    applyStimulus(0, NUM_CH'(1 << 3), d, 1);
    applyStimulus(0, '0, rand_data(), 1);
    checkOutput("beat_valid", 0, 32'(dut_out_valid[0]), 32'd1);
    checkOutput("beat_data", 0, 32'(dut_out_data[0]), 32'hA5);
    checkOutput("beat_id", 0, 32'(dut_out_id[0]), 32'd3);
    checkOutput("beat_id", 1, 32'(dut_out_id[1]), 32'd3);
    applyStimulus(0, '0, rand_data(), 1);
    checkOutput("beat_xfer", 0, 32'(dut_xfer_cnt[0]), 32'd1);

    // Round-robin fairness with every channel valid.
    applyStimulus(1, '0, '0, 1);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(0, '1, rand_data(), 1);
      if (dut_out_valid[0]) ids.push_back(int'(dut_out_id[0]));
    end
    checkOutput("rr_count", 0, 32'(ids.size() >= 11), 32'd1);
    for (int k = 0; k < 11 && k < ids.size(); k++) checkOutput("rr_seq", 0, 32'(ids[k]), 32'(k % NUM_CH));

    // Fixed priority: channels 2 and 7 competing.
    applyStimulus(1, '0, '0, 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, NUM_CH'((1 << 2) | (1 << 7)), rand_data(), 1);
      if (dut_out_valid[1]) begin
        seen++;
        checkOutput("fixed_id", 1, 32'(dut_out_id[1]), 32'd2);
      end
    end
    checkOutput("fixed_seen", 1, 32'(seen), 32'd9);

    // Backpressure on channel 0: three accepts, then stall.
    applyStimulus(1, '0, '0, 0);
    for (int k = 0; k < 6; k++) begin
      d = '0;
      d[DATA_W-1:0] = DATA_W'(8'h10 + k);
      applyStimulus(0, NUM_CH'(1), d, 0);
    end
    checkOutput("bp_in_ready", 0, 32'(dut_in_ready[0][0]), 32'd0);
    checkOutput("bp_hold", 0, 32'(dut_out_data[0]), 32'h10);
    applyStimulus(0, '0, '0, 1);
    checkOutput("bp_drain1", 0, 32'(dut_out_data[0]), 32'h11);
    applyStimulus(0, '0, '0, 1);
    checkOutput("bp_drain2", 0, 32'(dut_out_data[0]), 32'h12);
    applyStimulus(0, '0, '0, 1);
    checkOutput("bp_empty", 0, 32'(dut_out_valid[0]), 32'd0);

    // Reset mid-stream discards everything buffered.
    applyStimulus(1, '0, '0, 1);
    for (int k = 0; k < 4; k++) applyStimulus(0, '1, rand_data(), 0);
    applyStimulus(1, '1, rand_data(), 1);
    checkOutput("mid_rst_valid", 0, 32'(dut_out_valid[0]), 32'd0);
    checkOutput("mid_rst_xfer", 1, 32'(dut_xfer_cnt[1]), 32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(0, '0, '0, 1);
    checkOutput("mid_rst_empty", 0, 32'(dut_out_valid[0]), 32'd0);

    // Randomised traffic with occasional reset pulses.
    for (int k = 0; k < 800; k++) begin
      applyStimulus(($urandom_range(0, 99) == 0), NUM_CH'($urandom), rand_data(),
                    ($urandom_range(0, 9) < 7));
    end

    // Counter wrap after 65536 transfers.
    applyStimulus(1, '0, '0, 1);
    hs = 0;
    for (int k = 0; k < 70000 && hs < 65536; k++) begin
      if (dut_out_valid[0]) hs++;
      applyStimulus(0, '1, rand_data(), 1);
      if (hs == 65535) checkOutput("wrap_max", 0, 32'(dut_xfer_cnt[0]), 32'hFFFF);
    end
    checkOutput("wrap_reached", 0, 32'(hs), 32'd65536);
    applyStimulus(0, '0, '0, 0);
    checkOutput("wrap_zero", 0, 32'(dut_xfer_cnt[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
